// File: rtl/bit_serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
//
// Handshake: the master raises start with a, b and bin valid; the slave
// accepts them on the first rising edge where it is idle (busy=0, done=0).
// While busy or done is high, start is ignored. done is a one-cycle pulse
// that marks diff/bout as updated; diff/bout hold until the next done.
interface bit_serial_subtractor_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first.
// Fixed latency: N SHIFT cycles followed by a one-cycle DONE pulse.
module bit_serial_subtractor #(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  bit_serial_subtractor_if.slave  bus,
  output logic [1:0]              dbg_state
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  r_sh;
  logic          borrow;
  logic [CW-1:0] cnt;

  logic          x;
  logic          y;
  logic          dbit;
  logic          nborrow;
  logic [N-1:0]  r_next;

  assign dbg_state = state;

  // Full-subtractor on the current LSBs plus the result word after this shift.
  always_comb begin
    x       = a_sh[0];
    y       = b_sh[0];
    dbit    = x ^ y ^ borrow;
    nborrow = (~x & y) | (y & borrow) | (borrow & ~x);
    r_next  = {dbit, r_sh[N-1:1]};
  end

  // Control FSM with datapath registers; busy/done/diff/bout are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            borrow   <= bus.bin;
            cnt      <= '0;
            state    <= SHIFT;
            bus.busy <= 1'b1;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          r_sh   <= r_next;
          borrow <= nborrow;
          cnt    <= cnt + CW'(1);
          // Last bit: publish the completed word and final borrow.
          if (cnt == CW'(N - 1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.diff <= r_next;
            bus.bout <= nborrow;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed testbench for bit_serial_subtractor (N=8 instance plus an
// exhaustive sweep on an N=4 instance).
module tb_bit_serial_subtractor;

  logic clk;
  logic rst;
  logic [1:0] st8;
  logic [1:0] st4;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [7:0] prev_diff;
  logic       prev_bout;

  bit_serial_subtractor_if #(.N(8)) bus8 ();
  bit_serial_subtractor_if #(.N(4)) bus4 ();

  bit_serial_subtractor #(.N(8)) u8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8),
    .dbg_state (st8)
  );

  bit_serial_subtractor #(.N(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus4),
    .dbg_state (st4)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // N cycles of SHIFT: busy high, done low, previous result held.
  task automatic busy_phase(input string tag);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus8.done), 32'd0);
      check({tag, "_diff_hold"}, 32'(bus8.diff), 32'(prev_diff));
      check({tag, "_bout_hold"}, 32'(bus8.bout), 32'(prev_bout));
      step();
    end
  endtask

  // Start one operation from IDLE, scramble inputs after acceptance,
  // check latency and result, return to IDLE.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                        input logic [7:0] ed, input logic eb, input string tag);
    bus8.a     = ta;
    bus8.b     = tb_v;
    bus8.bin   = tbin;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.a     = ~ta;
    bus8.b     = ~tb_v;
    bus8.bin   = ~tbin;
    busy_phase(tag);
    check({tag, "_done"}, 32'(bus8.done), 32'd1);
    check({tag, "_done_nobusy"}, 32'(bus8.busy), 32'd0);
    check({tag, "_diff"}, 32'(bus8.diff), 32'(ed));
    check({tag, "_bout"}, 32'(bus8.bout), 32'(eb));
    prev_diff = ed;
    prev_bout = eb;
    step();
    check({tag, "_idle_done"}, 32'(bus8.done), 32'd0);
    check({tag, "_idle_state"}, 32'(st8), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [3:0] ed4;
    logic       eb4;

    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.bin   = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus4.bin   = 1'b0;
    prev_diff  = 8'h00;
    prev_bout  = 1'b0;
    step();
    step();

    // Reset state (start high under reset must not be accepted)
    bus8.start = 1'b1;
    step();
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_diff", 32'(bus8.diff), 32'h00);
    check("rst_bout", 32'(bus8.bout), 32'd0);
    check("rst_state", 32'(st8), 32'd0);
    bus8.start = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst_idle", 32'(bus8.busy), 32'd0);

    // Directed vectors
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "basic");
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "under1");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "under2");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "ripple1");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ripple2");

    // start held high: back-to-back operations every N+2 cycles
    bus8.a     = 8'h10;
    bus8.b     = 8'h01;
    bus8.bin   = 1'b0;
    bus8.start = 1'b1;
    step();
    bus8.a = 8'hAA;
    bus8.b = 8'h55;
    busy_phase("hold1");
    check("hold1_done", 32'(bus8.done), 32'd1);
    check("hold1_diff", 32'(bus8.diff), 32'h0F);
    check("hold1_bout", 32'(bus8.bout), 32'd0);
    prev_diff = 8'h0F;
    prev_bout = 1'b0;
    bus8.a = 8'h20;
    bus8.b = 8'h03;
    step();
    check("hold_idle_busy", 32'(bus8.busy), 32'd0);
    check("hold_idle_done", 32'(bus8.done), 32'd0);
    check("hold_idle_state", 32'(st8), 32'd0);
    step();
    bus8.a = 8'hC3;
    bus8.b = 8'h3C;
    busy_phase("hold2");
    check("hold2_done", 32'(bus8.done), 32'd1);
    check("hold2_diff", 32'(bus8.diff), 32'h1D);
    check("hold2_bout", 32'(bus8.bout), 32'd0);
    prev_diff = 8'h1D;
    bus8.start = 1'b0;
    step();
    step();
    check("hold_end_state", 32'(st8), 32'd0);

    // Reset in SHIFT cycle 4 (start also high to check priority)
    bus8.a     = 8'h05;
    bus8.b     = 8'h03;
    bus8.bin   = 1'b0;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    step();
    step();
    step();
    check("midrst_busy_before", 32'(bus8.busy), 32'd1);
    rst        = 1'b1;
    bus8.start = 1'b1;
    step();
    rst        = 1'b0;
    bus8.start = 1'b0;
    check("midrst_busy", 32'(bus8.busy), 32'd0);
    check("midrst_done", 32'(bus8.done), 32'd0);
    check("midrst_diff", 32'(bus8.diff), 32'h00);
    check("midrst_bout", 32'(bus8.bout), 32'd0);
    check("midrst_state", 32'(st8), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("midrst_no_done", 32'(bus8.done), 32'd0);
      check("midrst_no_busy", 32'(bus8.busy), 32'd0);
      step();
    end
    prev_diff = 8'h00;
    prev_bout = 1'b0;
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "after_rst");

    // Exhaustive sweep at N=4 against the arithmetic reference
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          bus4.a     = 4'(ia);
          bus4.b     = 4'(ib);
          bus4.bin   = 1'(ic);
          bus4.start = 1'b1;
          step();
          bus4.start = 1'b0;
          bus4.a     = 4'($urandom_range(0, 15));
          bus4.b     = 4'($urandom_range(0, 15));
          bus4.bin   = 1'($urandom_range(0, 1));
          cyc = 0;
          while (bus4.done !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
          end
          ed4 = 4'((ia - ib - ic) & 15);
          eb4 = (ia < ib + ic) ? 1'b1 : 1'b0;
          check("ex4_latency", 32'(cyc), 32'd4);
          check("ex4_diff", 32'(bus4.diff), 32'(ed4));
          check("ex4_bout", 32'(bus4.bout), 32'(eb4));
          step();
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
